// File: rtl/pipeline_types.sv
// Pipeline-internal control types.
package pipeline_types;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

  // radix-2 iterations needed for a 32-bit multiply or divide
  localparam int MULDIV_STEPS = 32;

endpackage

// File: rtl/rv32i_types.sv
// RV32I/M instruction-level types shared across the pipeline.
package rv32i_types;

  // funct3 encoding of the M-extension instructions
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Unsigned iterative core: shift-add multiply and restoring divide on
// operand magnitudes. The accumulator low half doubles as multiplier
// shift register (multiply) or dividend/quotient shift register (divide).
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  // multiplicand (multiply) or divisor (divide) magnitude
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     prem;
  logic               div_mode;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               rem_ge;

  // next-step arithmetic for both algorithms
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {prem[WIDTH-1:0], acc[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd});
    rem_diff = rem_sh - {1'b0, opnd};
  end

  // load magnitudes on accept, then advance one radix-2 step per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd     <= '0;
      acc      <= '0;
      prem     <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      opnd     <= is_div ? mag_b : mag_a;
      acc      <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      prem     <= '0;
      div_mode <= is_div;
    end else if (step) begin
      if (div_mode) begin
        prem            <= rem_ge ? rem_diff : rem_sh;
        acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], rem_ge};
      end else begin
        acc <= {mul_sum, acc[WIDTH-1:1]};
      end
    end
  end

  assign product   = acc;
  assign quotient  = acc[WIDTH-1:0];
  assign remainder = prem[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit for the execute stage. Holds the pipeline via
// stall while iterating; divide-by-zero and signed overflow bypass the
// iteration and resolve directly in FIX.
module muldiv_unit
  import rv32i_types::*;
  import pipeline_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  muldiv_state_t    state;
  logic [4:0]       count;
  muldiv_op_t       op_q;
  logic             neg_a_q;
  logic             neg_b_q;
  logic             special_q;
  logic [WIDTH-1:0] special_val_q;

  logic             a_signed, b_signed;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_val;
  logic             load, step;

  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient, remainder;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s;
  logic [WIDTH-1:0]   fix_val;

  // operand signedness, magnitudes and special-case detection in IDLE
  always_comb begin
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    neg_a    = a_signed && a[WIDTH-1];
    neg_b    = b_signed && b[WIDTH-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    // op[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero)
      special_val = op[1] ? a : {WIDTH{1'b1}};
    else
      special_val = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  assign load  = (state == ST_IDLE) && start && !flush;
  assign step  = (state == ST_CALC) && !flush;
  assign stall = start && (state != ST_DONE) && !flush;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .is_div    (op[2]),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // sign correction and half/quotient/remainder selection for FIX
  always_comb begin
    prod_s  = (neg_a_q ^ neg_b_q) ? -product : product;
    quot_s  = (neg_a_q ^ neg_b_q) ? -quotient : quotient;
    rem_s   = neg_a_q ? -remainder : remainder;
    fix_val = '0;
    case (op_q)
      OP_MUL:                        fix_val = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               fix_val = quot_s;
      OP_REM, OP_REMU:               fix_val = rem_s;
      default:                       fix_val = '0;
    endcase
  end

  // control FSM with registered done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      count         <= '0;
      op_q          <= OP_MUL;
      neg_a_q       <= 1'b0;
      neg_b_q       <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      done          <= 1'b0;
      result        <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              op_q          <= op;
              neg_a_q       <= neg_a;
              neg_b_q       <= neg_b;
              special_q     <= div_zero || div_ovf;
              special_val_q <= special_val;
              count         <= '0;
              state         <= (div_zero || div_ovf) ? ST_FIX : ST_CALC;
            end
          end
          ST_CALC: begin
            count <= count + 5'd1;
            if (count == 5'(MULDIV_STEPS - 1))
              state <= ST_FIX;
          end
          ST_FIX: begin
            result <= special_q ? special_val_q : fix_val;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: per-cycle comparison of stall, done
// and result against expectations derived from a plain-arithmetic model.
module tb_muldiv_unit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  muldiv_op_t  op = OP_MUL;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  logic        checking   = 1'b0;
  logic        exp_stall  = 1'b0;
  logic        exp_done   = 1'b0;
  logic [31:0] exp_result = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] ref_result(input muldiv_op_t o, input logic [31:0] x,
                                              input logic [31:0] y);
    longint     sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    p  = '0;
    case (o)
      OP_MUL:    begin p = sx * sy; return p[31:0];  end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * uy; return p[63:32]; end
      OP_MULHU:  begin p = ux * uy; return p[63:32]; end
      OP_DIV: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sx / sy; return p[31:0];
      end
      OP_DIVU: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      OP_REM: begin
        if (y == 32'h0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 32'h0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input muldiv_op_t o, input logic [31:0] x,
                                    input logic [31:0] y);
    if (o == OP_DIV || o == OP_DIVU || o == OP_REM || o == OP_REMU) begin
      if (y == 32'h0) return 1'b1;
      if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // single compare point, half a cycle away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      chk("stall", {31'h0, stall}, {31'h0, exp_stall});
      chk("done", {31'h0, done}, {31'h0, exp_done});
      chk("result", result, exp_result);
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    exp_stall = 1'b0; exp_done = 1'b0;
  endtask

  // one instruction from acceptance (cycle 0) through its done cycle;
  // forwarded operands are scrambled once the instruction is accepted
  task automatic run_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    int          lat;
    logic [31:0] r;
    lat = is_special(o, x, y) ? 2 : 34;
    r   = ref_result(o, x, y);
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b0; op = o; a = x; b = y;
    exp_stall = 1'b1; exp_done = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      a  = $urandom;
      b  = $urandom;
      op = muldiv_op_t'($urandom_range(0, 7));
      exp_stall = (k < lat);
      exp_done  = (k == lat);
      if (k == lat) exp_result = r;
    end
  endtask

  initial begin
    // model pinned against hand-computed values
    chk("pin_mul",    ref_result(OP_MUL,    32'd7,          32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulh",   ref_result(OP_MULH,   32'h8000_0000,  32'hFFFF_FFFF), 32'h0000_0000);
    chk("pin_mulhsu", ref_result(OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF), 32'h8000_0000);
    chk("pin_mulhu",  ref_result(OP_MULHU,  32'h8000_0000,  32'hFFFF_FFFF), 32'h7FFF_FFFF);
    chk("pin_div",    ref_result(OP_DIV,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFD);
    chk("pin_rem",    ref_result(OP_REM,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFF);
    chk("pin_divu",   ref_result(OP_DIVU,   32'hFFFF_FFFF,  32'h10),        32'h0FFF_FFFF);
    chk("pin_div0",   ref_result(OP_DIV,    32'd5,          32'd0),         32'hFFFF_FFFF);
    chk("pin_rem0",   ref_result(OP_REM,    32'd5,          32'd0),         32'd5);
    chk("pin_ovf",    ref_result(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF), 32'h0);

    // reset state, including stall following start while in reset
    checking = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; exp_stall = 1'b1;
    @(posedge clk); #1 start = 1'b0; exp_stall = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cycle();

    // directed vectors
    run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD);
    run_op(OP_MULH,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_MULHU,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2);
    run_op(OP_REM,    32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIVU,   32'hFFFF_FFFF, 32'h10);
    run_op(OP_DIV,    32'd5,         32'd0);
    run_op(OP_REM,    32'd5,         32'd0);
    run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF);
    idle_cycle();

    // flush in cycle 10 of a DIVU: back to idle, no done, result held
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
    exp_stall = 1'b1; exp_done = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin
        flush = 1'b1; exp_stall = 1'b0;
      end
    end
    repeat (4) idle_cycle();
    run_op(OP_DIVU, 32'd1000, 32'd7);

    // flush and start together: nothing accepted
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd3;
    exp_stall = 1'b0; exp_done = 1'b0;
    repeat (3) idle_cycle();

    // asynchronous reset mid-CALC
    @(posedge clk); #1;
    start = 1'b1; op = OP_MUL; a = 32'd12345; b = 32'd678;
    exp_stall = 1'b1; exp_done = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0; exp_result = 32'h0; exp_done = 1'b0; exp_stall = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; exp_stall = 1'b0;
    run_op(OP_MUL, 32'd12345, 32'd678);

    // randomized back-to-back traffic
    for (int i = 0; i < 80; i++)
      run_op(muldiv_op_t'($urandom_range(0, 7)), pick_operand(), pick_operand());
    idle_cycle();
    idle_cycle();

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, downstream of forwarding. It consumes the post-forwarding-mux `rs1`/`rs2` operands for M-extension instructions and holds the pipeline with `stall` until the result is ready. The result is then delivered into the execute result path alongside the ALU output.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; must stay 32 for RV32M.

Ports:
- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  execute holds a valid M-extension instruction.
- `op`  in  3  funct3 of the instruction, as `muldiv_op_t`: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `a`  in  32  forwarded rs1 value.
- `b`  in  32  forwarded rs2 value.
- `flush`  in  1  execute instruction squashed (branch mispredict).
- `stall`  out  1  combinational; hold IF/ID/EX and bubble MEM.
- `done`  out  1  registered; one-cycle result-valid pulse.
- `result`  out  32  registered; valid while `done` is high, held until the next accepted `start`.

## Operation
States:
- IDLE:
  - `start` && !`flush` → latch `a`, `b`, `op`, and the operand signs.
  - Special-case divide → FIX; otherwise → CALC with `count`=0.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring divide on magnitudes with a 33-bit partial remainder.
  - `count`==31 → FIX.
- FIX: apply sign correction and select the half/quotient/remainder.
  - Register `result`, raise `done` → DONE.
- DONE: `done`=1 for exactly this cycle; `start` is ignored; → IDLE.

Stall and flush:
- `stall` = `start` && state≠DONE && !`flush`.
- `flush` in any state → IDLE next cycle; `done` is suppressed; `result` is unchanged.

Arithmetic:
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - Others: unsigned.
- Magnitudes are taken in IDLE. The final product or quotient is negated iff the operand signs differ (signed operands only). The remainder takes the sign of the dividend.
- MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide by zero (`b`==0, skips CALC):
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → `a`.
- Signed overflow (`a`==0x80000000, `b`==0xFFFFFFFF, DIV/REM, skips CALC):
  - DIV → 0x80000000.
  - REM → 0.

Reset (`rst_n` low, asynchronous, including mid-operation):
- state=IDLE, `count`=0, internal accumulators 0.
- `done`=0, `result`=0, so `stall` reflects `start` only.

## Timing
- Normal latency: `start` accepted in cycle 0 (IDLE).
  - CALC occupies cycles 1–32, FIX cycle 33, `done`/`result` valid in cycle 34.
  - `stall` is high for cycles 0–33 and low in cycle 34, so the instruction advances from EX at the end of cycle 34.
- Special-case latency: IDLE (cycle 0) → FIX (cycle 1) → DONE (cycle 2); `stall` is high for cycles 0–1.
- Back-to-back: a new `start` in the cycle after DONE is accepted normally. There is no throughput overlap.
- `flush` and `start` in the same cycle: `flush` wins; nothing is accepted.
- Operands are sampled only in IDLE. Forwarded values changing during CALC have no effect.

## Structure
- `muldiv_op_t` (3-bit enum matching funct3) belongs in `rv32i_types`.
- The `muldiv_state_t` enum and the constant `MULDIV_STEPS`=32 belong in `pipeline_types`.
- One sub-module, `muldiv_datapath`:
  - Holds the magnitude registers, 64-bit accumulator, 33-bit partial remainder, and step logic.
  - Controlled by `load`/`step`/`is_div` from the FSM in `muldiv_unit`.
- Sign fix-up and special-case muxing stay in `muldiv_unit`.

## Test plan
- MUL a=7, b=−3 (0xFFFFFFFD) → `result`=0xFFFFFFEB at cycle 34; `stall` high for exactly 34 cycles; `done` a single-cycle pulse.
- MULH/MULHSU/MULHU with a=0x80000000, b=0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV a=−7, b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF.
- DIV a=5, b=0 → 0xFFFFFFFF with `done` at cycle 2; REM → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Interruptions:
  - `flush` asserted at cycle 10 of a DIVU → IDLE next cycle, no `done`, prior `result` held.
  - `rst_n` low mid-CALC → `done`=0 and `result`=0 immediately; the next `start` completes correctly.
